// File: rtl/display_timing_480p.sv
// Pixel-clock timing generator for 640x480@60: free-running h/v counters with a
// registered decode stage, so every output on a cycle describes the same pixel.
module display_timing_480p #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int FCW    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_cordw_too_small
      $error("display_timing_480p: H_TOTAL/V_TOTAL do not fit in CORDW bits");
    end
  endgenerate

  logic [CORDW-1:0] hc_q, hc_d;
  logic [CORDW-1:0] vc_q, vc_d;
  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             started_q, started_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

  always_comb begin
    hc_d = hc_q + CORDW'(1);
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CORDW'(1);
    end

    sx_d    = hc_q;
    sy_d    = vc_q;
    hsync_d = (hc_q >= HS_BEG && hc_q <= HS_END) ? H_POL : ~H_POL;
    vsync_d = (vc_q >= VS_BEG && vc_q <= VS_END) ? V_POL : ~V_POL;
    de_d    = (hc_q < H_ACT) && (vc_q < V_ACT);
    line_d  = (hc_q == '0);
    frame_d = line_d && (vc_q == '0);

    // The frame registered right after reset is frame 0, so it is not counted.
    started_d   = started_q | frame_d;
    frame_cnt_d = (frame_d && started_q) ? frame_cnt_q + FCW'(1) : frame_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hc_q        <= '0;
      vc_q        <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      started_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      started_q   <= started_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sx        = sx_q;
  assign sy        = sy_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign line      = line_q;
  assign frame     = frame_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timing_480p.sv
// Bench for display_timing_480p: a full-size 640x480 instance for line timing and
// a shrunken, inverted-polarity, FCW=2 instance so whole frames fit in a short run.
module tb_display_timing_480p;

  typedef struct packed {
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ln;
    logic        fr;
    logic [15:0] fc;
  } exp_t;

  localparam int S_HR = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VR = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HR + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VR + S_VF + S_VS + S_VB;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_big = 1'b0;
  logic        rst_sml = 1'b0;

  logic [9:0]  b_sx, b_sy;
  logic        b_hs, b_vs, b_de, b_ln, b_fr;
  logic [15:0] b_fc;

  logic [5:0]  s_sx, s_sy;
  logic        s_hs, s_vs, s_de, s_ln, s_fr;
  logic [1:0]  s_fc;

  display_timing_480p u_big (
    .i_clk(clk), .i_rst(rst_big),
    .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .line(b_ln), .frame(b_fr), .frame_cnt(b_fc)
  );

  display_timing_480p #(
    .CORDW(6), .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b1), .V_POL(1'b1), .FCW(2)
  ) u_sml (
    .i_clk(clk), .i_rst(rst_sml),
    .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .line(s_ln), .frame(s_fr), .frame_cnt(s_fc)
  );

  exp_t act_b, act_s;
  assign act_b = {b_sx, b_sy, b_hs, b_vs, b_de, b_ln, b_fr, b_fc};
  assign act_s = {4'b0, s_sx, 4'b0, s_sy, s_hs, s_vs, s_de, s_ln, s_fr, 14'b0, s_fc};

  // Clock edges seen since each instance's reset was released.
  int n_big, n_sml;
  always @(posedge clk or negedge rst_big)
    if (!rst_big) n_big <= 0; else n_big <= n_big + 1;
  always @(posedge clk or negedge rst_sml)
    if (!rst_sml) n_sml <= 0; else n_sml <= n_sml + 1;

  int errors = 0;
  int checks = 0;

  // Edge n after release shows raster position n-1, walked in row-major order.
  function automatic exp_t model(int n, int hr, int hf, int hsw, int hb,
                                 int vr, int vf, int vsw, int vb,
                                 bit hp, bit vp, int fcw);
    exp_t e;
    int ht, vt, p, x, y, f;
    ht = hr + hf + hsw + hb;
    vt = vr + vf + vsw + vb;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (n == 0) return e;
    p = n - 1;
    x = p % ht;
    y = (p / ht) % vt;
    f = (p / (ht * vt)) % (1 << fcw);
    e.sx = 10'(x);
    e.sy = 10'(y);
    e.hs = (x >= hr + hf && x < hr + hf + hsw) ? hp : ~hp;
    e.vs = (y >= vr + vf && y < vr + vf + vsw) ? vp : ~vp;
    e.de = (x < hr) && (y < vr);
    e.ln = (x == 0);
    e.fr = (x == 0) && (y == 0);
    e.fc = 16'(f);
    return e;
  endfunction

  function automatic exp_t mb(int n);
    return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16);
  endfunction

  function automatic exp_t ms(int n);
    return model(n, S_HR, S_HF, S_HS, S_HB, S_VR, S_VF, S_VS, S_VB, 1'b1, 1'b1, 2);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_big = 1'b0;
    rst_sml = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (act_b !== mb(0)) begin
      errors++; $display("FAIL reset_big got=%h want=%h", act_b, mb(0));
    end
    checks++;
    if (act_s !== ms(0)) begin
      errors++; $display("FAIL reset_sml got=%h want=%h", act_s, ms(0));
    end
    checks++;
    if ({s_hs, s_vs} !== 2'b00) begin
      errors++; $display("FAIL reset_pol_inv got=%b want=00", {s_hs, s_vs});
    end
    rst_big = 1'b1;
    rst_sml = 1'b1;
    @(negedge clk);
    e = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b1; e.ln = 1'b1; e.fr = 1'b1;
    checks++;
    if (act_b !== e) begin
      errors++; $display("FAIL first_edge got=%h want=%h", act_b, e);
    end
    @(negedge clk);
    e.sx = 10'd1; e.ln = 1'b0; e.fr = 1'b0;
    checks++;
    if (act_b !== e) begin
      errors++; $display("FAIL second_edge got=%h want=%h", act_b, e);
    end
  endtask

  task automatic test_line();
    int len, last_ln, de_run, hs_run, nlines;
    len = 1700 + int'($urandom_range(0, 600));
    last_ln = -1; de_run = 0; hs_run = 0; nlines = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      checks++;
      if (act_b !== mb(n_big)) begin
        errors++; $display("FAIL line_model n=%0d got=%h want=%h", n_big, act_b, mb(n_big));
      end
      if (b_ln) begin
        if (last_ln >= 0) begin
          checks++;
          if (c - last_ln != 800) begin
            errors++; $display("FAIL line_period got=%0d want=800", c - last_ln);
          end
        end
        last_ln = c;
        nlines++;
      end
      if (last_ln >= 0) begin
        if (b_de) de_run++;
        else begin
          if (de_run > 0) begin
            checks++;
            if (de_run != 640) begin
              errors++; $display("FAIL de_run got=%0d want=640", de_run);
            end
          end
          de_run = 0;
        end
        if (!b_hs) hs_run++;
        else begin
          if (hs_run > 0) begin
            checks++;
            if (hs_run != 96) begin
              errors++; $display("FAIL hsync_run got=%0d want=96", hs_run);
            end
          end
          hs_run = 0;
        end
      end
    end
    checks++;
    if (nlines < 2) begin
      errors++; $display("FAIL line_count got=%0d want>=2", nlines);
    end
  endtask

  task automatic test_frame();
    int len, last_fr, ln_cnt, vs_cnt, nframes;
    rst_sml = 1'b0;
    repeat (2 + int'($urandom_range(0, 4))) @(negedge clk);
    rst_sml = 1'b1;
    len = 5 * S_FRAME + 2 + int'($urandom_range(0, 400));
    last_fr = -1; ln_cnt = 0; vs_cnt = 0; nframes = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      checks++;
      if (act_s !== ms(n_sml)) begin
        errors++; $display("FAIL frame_model n=%0d got=%h want=%h", n_sml, act_s, ms(n_sml));
      end
      if (s_fr) begin
        if (last_fr >= 0) begin
          checks++;
          if (c - last_fr != S_FRAME || ln_cnt != S_VT || vs_cnt != S_VS * S_HT) begin
            errors++;
            $display("FAIL frame_stats period=%0d lines=%0d vs=%0d want %0d/%0d/%0d",
                     c - last_fr, ln_cnt, vs_cnt, S_FRAME, S_VT, S_VS * S_HT);
          end
        end
        last_fr = c; ln_cnt = 0; vs_cnt = 0;
        nframes++;
      end
      if (s_ln) ln_cnt++;
      if (s_vs) vs_cnt++;
      if (s_sy >= 6'(S_VR)) begin
        checks++;
        if (s_de !== 1'b0) begin
          errors++; $display("FAIL de_in_vblank sy=%0d got=%b want=0", s_sy, s_de);
        end
      end
      if (n_sml == 3 * S_FRAME + 1 || n_sml == 4 * S_FRAME + 1 || n_sml == 5 * S_FRAME + 1) begin
        checks++;
        if (s_fc !== 2'((n_sml - 1) / S_FRAME)) begin
          errors++;
          $display("FAIL frame_cnt_wrap n=%0d got=%0d want=%0d", n_sml, s_fc,
                   ((n_sml - 1) / S_FRAME) % 4);
        end
      end
    end
    checks++;
    if (nframes < 6) begin
      errors++; $display("FAIL frame_count got=%0d want>=6", nframes);
    end
  endtask

  task automatic test_mid_reset();
    int last_fr, last_ln, nfr, len;
    repeat (30 + int'($urandom_range(0, 330))) @(negedge clk);
    @(posedge clk);
    #2 rst_sml = 1'b0;
    #1;
    checks++;
    if (act_s !== ms(0)) begin
      errors++; $display("FAIL midreset_sml_async got=%h want=%h", act_s, ms(0));
    end
    repeat (100 + int'($urandom_range(0, 1400))) @(negedge clk);
    @(posedge clk);
    #2 rst_big = 1'b0;
    #1;
    checks++;
    if (act_b !== mb(0)) begin
      errors++; $display("FAIL midreset_big_async got=%h want=%h", act_b, mb(0));
    end
    repeat (1 + int'($urandom_range(0, 3))) begin
      @(negedge clk);
      checks++;
      if (act_b !== mb(0) || act_s !== ms(0)) begin
        errors++; $display("FAIL midreset_hold got=%h/%h", act_b, act_s);
      end
    end
    rst_sml = 1'b1;
    rst_big = 1'b1;
    len = 2 * S_FRAME + 1 + int'($urandom_range(0, 100));
    last_fr = -1; last_ln = -1; nfr = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      checks++;
      if (act_s !== ms(n_sml) || act_b !== mb(n_big)) begin
        errors++;
        $display("FAIL restart_model n=%0d got=%h/%h want=%h/%h", n_sml, act_s, act_b,
                 ms(n_sml), mb(n_big));
      end
      if (s_fr) begin
        if (last_fr < 0) begin
          checks++;
          if (c != 0) begin
            errors++; $display("FAIL restart_first_frame got=%0d want=0", c);
          end
        end else begin
          checks++;
          if (c - last_fr != S_FRAME) begin
            errors++; $display("FAIL restart_frame_period got=%0d want=%0d", c - last_fr, S_FRAME);
          end
        end
        last_fr = c;
        nfr++;
      end
      if (b_ln) begin
        if (last_ln >= 0) begin
          checks++;
          if (c - last_ln != 800) begin
            errors++; $display("FAIL restart_line_period got=%0d want=800", c - last_ln);
          end
        end
        last_ln = c;
      end
    end
    checks++;
    if (nfr < 3) begin
      errors++; $display("FAIL restart_frames got=%0d want>=3", nfr);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
